// File: rtl/posit_argmax_classifier_if.sv
`default_nettype none
// ============================================================================
// Module   : posit_argmax_classifier_if
// Purpose  : Handshake bundle between the last posit layer, the argmax
//            classifier and the DMA write-back stream.
// Signals  : rts_i/rtr_o/eow_i/posit_i - upstream word stream
//            rts_o/rtr_i/eow_o/class_o/max_posit_o - downstream result stream
// Modports : slave  - classifier side
//            master - environment side (upstream layer + downstream DMA)
// Revision : 1.0 - initial release
// ============================================================================
interface posit_argmax_classifier_if #(
  parameter int NB_CLASSES  = 20,
  parameter int POSIT_WIDTH = 16
);
  localparam int CLASS_W = $clog2(NB_CLASSES);

  logic                   rtr_o;
  logic                   rts_i;
  logic                   eow_i;
  logic [POSIT_WIDTH-1:0] posit_i;
  logic                   rtr_i;
  logic                   rts_o;
  logic                   eow_o;
  logic [CLASS_W-1:0]     class_o;
  logic [POSIT_WIDTH-1:0] max_posit_o;

  modport slave (
    output rtr_o,
    input  rts_i,
    input  eow_i,
    input  posit_i,
    input  rtr_i,
    output rts_o,
    output eow_o,
    output class_o,
    output max_posit_o
  );

  modport master (
    input  rtr_o,
    output rts_i,
    output eow_i,
    output posit_i,
    output rtr_i,
    input  rts_o,
    input  eow_o,
    input  class_o,
    input  max_posit_o
  );
endinterface
`default_nettype wire

// File: rtl/posit_argmax_classifier.sv
`default_nettype none
// ============================================================================
// Module   : posit_argmax_classifier
// Purpose  : Per-frame argmax over a stream of posits. Each frame holds
//            NB_CLASSES posits (or fewer when the DMA tail ends it with
//            eow_i); one result {class index, max posit, eow} is emitted
//            per frame.
// Ports    : clk, rst (synchronous, active-high)
//            bus (slave modport of posit_argmax_classifier_if):
//              rts_i/rtr_o/eow_i/posit_i     upstream words
//              rts_o/rtr_i/eow_o/class_o/max_posit_o  downstream result
// Options  : ARGMAX_SKID_EN - one-entry result skid buffer so a new frame
//            can be accumulated while a result waits downstream.
// Revision : 1.0 - initial release
// ============================================================================
module posit_argmax_classifier #(
  parameter int NB_CLASSES  = 20,
  parameter int POSIT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  posit_argmax_classifier_if.slave   bus
);
  localparam int                 CLASS_W  = $clog2(NB_CLASSES);
  localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(NB_CLASSES - 1);

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } state_t;

  state_t                 state;
  logic [CLASS_W-1:0]     wc;
  logic [POSIT_WIDTH-1:0] run_max;
  logic [CLASS_W-1:0]     run_idx;
  logic                   eow_acc;

  logic                   rtr_q;
  logic                   rts_q;
  logic                   eow_q;
  logic [CLASS_W-1:0]     class_q;
  logic [POSIT_WIDTH-1:0] max_q;

`ifdef ARGMAX_SKID_EN
  logic                   skid_full;
  logic [CLASS_W-1:0]     skid_class;
  logic [POSIT_WIDTH-1:0] skid_max;
  logic                   skid_eow;
`endif

  logic                   accept;
  logic                   first_word;
  logic                   take_word;
  logic                   frame_end;
  logic [POSIT_WIDTH-1:0] next_max;
  logic [CLASS_W-1:0]     next_idx;
  logic                   next_eow;

  // Two's-complement order equals posit order, and NaR (0x80..0) is the most
  // negative code, so a strict signed compare never lets NaR beat a real value
  // and keeps the lower index on ties.
  always_comb begin
    accept     = bus.rts_i & rtr_q;
    first_word = (wc == '0);
    take_word  = first_word | ($signed(bus.posit_i) > $signed(run_max));
    next_max   = take_word ? bus.posit_i : run_max;
    next_idx   = take_word ? wc : run_idx;
    // Flag restarts with each frame, then accumulates any eow seen in it.
    next_eow   = (~first_word & eow_acc) | bus.eow_i;
    frame_end  = accept & ((wc == LAST_IDX) | bus.eow_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACCUM;
      wc      <= '0;
      run_max <= '0;
      run_idx <= '0;
      eow_acc <= 1'b0;
      rtr_q   <= 1'b1;
      rts_q   <= 1'b0;
      eow_q   <= 1'b0;
      class_q <= '0;
      max_q   <= '0;
`ifdef ARGMAX_SKID_EN
      skid_full  <= 1'b0;
      skid_class <= '0;
      skid_max   <= '0;
      skid_eow   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        wc      <= frame_end ? '0 : wc + 1'b1;
        run_max <= next_max;
        run_idx <= next_idx;
        eow_acc <= next_eow;
      end

`ifdef ARGMAX_SKID_EN
      case (state)
        ACCUM: begin
          if (frame_end) begin
            class_q <= next_idx;
            max_q   <= next_max;
            eow_q   <= next_eow;
            rts_q   <= 1'b1;
            state   <= OUTPUT;
          end
        end
        OUTPUT: begin
          // rtr_q is low while the skid is full, so a frame can only end
          // here when the skid is empty.
          if (bus.rtr_i) begin
            if (skid_full) begin
              class_q   <= skid_class;
              max_q     <= skid_max;
              eow_q     <= skid_eow;
              skid_full <= 1'b0;
              rtr_q     <= 1'b1;
            end else if (frame_end) begin
              class_q <= next_idx;
              max_q   <= next_max;
              eow_q   <= next_eow;
            end else begin
              rts_q <= 1'b0;
              state <= ACCUM;
            end
          end else if (frame_end) begin
            skid_class <= next_idx;
            skid_max   <= next_max;
            skid_eow   <= next_eow;
            skid_full  <= 1'b1;
            rtr_q      <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
`else
      case (state)
        ACCUM: begin
          if (frame_end) begin
            class_q <= next_idx;
            max_q   <= next_max;
            eow_q   <= next_eow;
            rts_q   <= 1'b1;
            rtr_q   <= 1'b0;
            state   <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (bus.rtr_i) begin
            rts_q <= 1'b0;
            rtr_q <= 1'b1;
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
`endif
    end
  end

  assign bus.rtr_o       = rtr_q;
  assign bus.rts_o       = rts_q;
  assign bus.eow_o       = eow_q;
  assign bus.class_o     = class_q;
  assign bus.max_posit_o = max_q;

endmodule
`default_nettype wire

// File: tb/tb_posit_argmax_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_posit_argmax_classifier
// Purpose  : Directed self-checking bench for posit_argmax_classifier with
//            NB_CLASSES=4, POSIT_WIDTH=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_posit_argmax_classifier;
  localparam int NB  = 4;
  localparam int PW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  posit_argmax_classifier_if #(.NB_CLASSES(NB), .POSIT_WIDTH(PW)) bus ();

  posit_argmax_classifier #(.NB_CLASSES(NB), .POSIT_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until it is accepted (bounded).
  task automatic send(input logic [PW-1:0] w, input logic e);
    int n;
    n = 0;
    bus.rts_i   = 1'b1;
    bus.posit_i = w;
    bus.eow_i   = e;
    while (!bus.rtr_o && n < 50) begin
      tick();
      n++;
    end
    if (!bus.rtr_o) check_val("accept_timeout", {31'd0, bus.rtr_o}, 32'd1);
    tick();
    bus.rts_i = 1'b0;
    bus.eow_i = 1'b0;
  endtask

  task automatic send_frame(input logic [PW-1:0] a, b, c, d);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
    send(d, 1'b0);
  endtask

  task automatic check_result(input string tag, input logic [1:0] cls,
                              input logic [PW-1:0] mx, input logic e);
    check_val({tag, "_rts"}, {31'd0, bus.rts_o}, 32'd1);
    check_val({tag, "_cls"}, {30'd0, bus.class_o}, {30'd0, cls});
    check_val({tag, "_max"}, {16'd0, bus.max_posit_o}, {16'd0, mx});
    check_val({tag, "_eow"}, {31'd0, bus.eow_o}, {31'd0, e});
  endtask

  // Downstream takes the result on the next edge (rtr_i assumed high).
  task automatic consume(input string tag);
    tick();
    check_val({tag, "_drain"}, {31'd0, bus.rts_o}, 32'd0);
  endtask

  initial begin
    bus.rts_i   = 1'b0;
    bus.eow_i   = 1'b0;
    bus.posit_i = '0;
    bus.rtr_i   = 1'b1;
    rst         = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_val("rst_rtr", {31'd0, bus.rtr_o}, 32'd1);
    check_val("rst_rts", {31'd0, bus.rts_o}, 32'd0);
    check_val("rst_eow", {31'd0, bus.eow_o}, 32'd0);
    check_val("rst_cls", {30'd0, bus.class_o}, 32'd0);
    check_val("rst_max", {16'd0, bus.max_posit_o}, 32'd0);

    // Basic frame with latency check
    send(16'h4000, 1'b0);
    send(16'h6000, 1'b0);
    send(16'hC000, 1'b0);
    check_val("basic_early", {31'd0, bus.rts_o}, 32'd0);
    send(16'h0000, 1'b0);
    check_result("basic", 2'd1, 16'h6000, 1'b0);
`ifndef ARGMAX_SKID_EN
    check_val("basic_rtr_out", {31'd0, bus.rtr_o}, 32'd0);
`endif
    consume("basic");
    check_val("basic_rtr_back", {31'd0, bus.rtr_o}, 32'd1);

    // Ties keep the lowest index
    send_frame(16'h4000, 16'h4000, 16'h2000, 16'h4000);
    check_result("tie", 2'd0, 16'h4000, 1'b0);
    consume("tie");

    // All NaR
    send_frame(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    check_result("nar", 2'd0, 16'h8000, 1'b0);
    consume("nar");

    // Negatives only: -16384, -8192, -4096, -12288
    send_frame(16'hC000, 16'hE000, 16'hF000, 16'hD000);
    check_result("neg", 2'd2, 16'hF000, 1'b0);
    consume("neg");

    // Backpressure
    bus.rtr_i = 1'b0;
    send_frame(16'h1000, 16'h2000, 16'h3000, 16'h7000);
`ifdef ARGMAX_SKID_EN
    send_frame(16'h5000, 16'h1000, 16'h1000, 16'h1000);
    for (int i = 0; i < 10; i++) begin
      check_val("bp_hold_max", {16'd0, bus.max_posit_o}, 32'h7000);
      check_val("bp_hold_rtr", {31'd0, bus.rtr_o}, 32'd0);
      tick();
    end
    check_result("bp_a", 2'd3, 16'h7000, 1'b0);
    bus.rtr_i = 1'b1;
    tick();
    check_result("bp_b", 2'd0, 16'h5000, 1'b0);
    consume("bp_b");
`else
    bus.rts_i   = 1'b1;
    bus.posit_i = 16'h5000;
    for (int i = 0; i < 10; i++) begin
      check_val("bp_hold_max", {16'd0, bus.max_posit_o}, 32'h7000);
      check_val("bp_hold_rtr", {31'd0, bus.rtr_o}, 32'd0);
      tick();
    end
    check_result("bp_a", 2'd3, 16'h7000, 1'b0);
    bus.rtr_i = 1'b1;
    consume("bp_a");
    send_frame(16'h5000, 16'h1000, 16'h1000, 16'h1000);
    check_result("bp_b", 2'd0, 16'h5000, 1'b0);
    consume("bp_b");
`endif

    // Short DMA tail frame
    send(16'h3000, 1'b0);
    send(16'h1000, 1'b0);
    send(16'h6000, 1'b1);
    check_result("eow", 2'd2, 16'h6000, 1'b1);
    consume("eow");
    send(16'h7000, 1'b0);
    check_val("eow_restart", {31'd0, bus.rts_o}, 32'd0);
    send(16'h1000, 1'b0);
    send(16'h2000, 1'b0);
    send(16'h3000, 1'b0);
    check_result("after_eow", 2'd0, 16'h7000, 1'b0);
    consume("after_eow");

    // Reset mid-frame
    send(16'h7000, 1'b0);
    send(16'h7000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mrst_rts", {31'd0, bus.rts_o}, 32'd0);
    check_val("mrst_rtr", {31'd0, bus.rtr_o}, 32'd1);
    check_val("mrst_max", {16'd0, bus.max_posit_o}, 32'd0);
    send(16'h0000, 1'b0);
    send(16'h0000, 1'b0);
    check_val("mrst_early", {31'd0, bus.rts_o}, 32'd0);
    send(16'h7000, 1'b0);
    send(16'h0000, 1'b0);
    check_result("mrst", 2'd2, 16'h7000, 1'b0);
    consume("mrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
